btn_repeat_ctrl: RTL and testbench
==================================

Name: btn_repeat_ctrl

Overview:
Input conditioning stage that sits directly upstream of flow_control. It takes the raw asynchronous usr_btn pins and produces debounced button levels and one-cycle press pulses. Selected buttons (move left/right, soft drop) also get Tetris-style auto-repeat: a delayed-auto-shift (DAS) wait, then periodic auto-repeat (ARR) pulses. It runs in the 25 MHz VGA/game clock domain and replaces ad-hoc edge detection on btn_pressed.

Parameters:
N_BTN, 4, number of buttons handled; all per-button logic is replicated.
DEBOUNCE_CYC, 250000, consecutive stable cycles needed to accept a level change (10 ms at 25 MHz); minimum 1.
DAS_DELAY_CYC, 4250000, cycles from the initial press pulse to the first repeat pulse (170 ms); minimum 1.
ARR_CYC, 1250000, cycles between subsequent repeat pulses (50 ms); minimum 1.
REPEAT_MASK, 4'b1011, bit i=1 enables auto-repeat for button i.

Ports:
clk  input  1  25 MHz game clock
reset  input  1  synchronous, active-high reset
btn_raw  input  N_BTN  raw asynchronous button pins (1 = pressed)
enable  input  1  1 = emit pulses; 0 = pulses suppressed (game paused/over)
btn_level  output  N_BTN  debounced button level
btn_pressed  output  N_BTN  one-cycle pulse per accepted press or repeat

Behaviour:
- Reset and clocking: one clock (clk). Reset is synchronous and active-high; reset has priority over all other logic.
- Reset values:
  - sync flops, btn_level, btn_pressed, debounce/repeat counters: all 0.
  - Repeat FSM: IDLE.
  - Lockout flags: 0.
- Synchroniser: 2-flop per bit; sync output lags btn_raw by 2 clk edges.
- Debounce, per bit:
  - Counter increments each cycle where sync != btn_level.
  - Counter clears on any cycle where sync == btn_level.
  - When the counter would reach DEBOUNCE_CYC, btn_level toggles and the counter clears.
  - Latency from a clean raw edge to btn_level change is exactly DEBOUNCE_CYC+2 cycles.
  - A glitch shorter than DEBOUNCE_CYC cycles produces no change.
- Counter widths are $clog2(max+1); there is no wrap. Counters saturate/clear as described and never overflow.
- Press pulse: btn_pressed[i]=1 in the first cycle btn_level[i] is 1, provided enable=1 and lockout[i]=0. Registered output, width exactly 1 cycle.
- Repeat FSM, per bit, active only if REPEAT_MASK[i]=1:
  - IDLE -> DAS on press pulse; repeat counter = 0.
  - DAS: counter counts up. At DAS_DELAY_CYC cycles after the press pulse, emit a pulse, clear the counter, go to ARR.
  - ARR: emit a pulse every ARR_CYC cycles.
  - Any state -> IDLE in the cycle btn_level falls. No pulse is emitted in that cycle, even if a repeat was due.
- Buttons with REPEAT_MASK[i]=0 produce exactly one pulse per press.
- enable=0:
  - btn_pressed is forced to 0 and all repeat FSMs go to IDLE.
  - Debounce continues and btn_level stays valid.
  - Any button with btn_level=1 while enable=0 sets lockout[i].
- Lockout: while lockout[i]=1, button i produces no pulses. lockout[i] clears when btn_level[i] falls, so the player must re-press after a pause or restart.
- Simultaneous events: buttons are fully independent. Multiple bits may pulse in the same cycle.
- Reset mid-hold: after reset deassertion, a held button is re-debounced from 0. It produces a fresh press pulse DEBOUNCE_CYC+2 cycles later if enable=1.

Optional Feature:
BTN_RELEASE_PULSE_EN
- Defined: adds output btn_released [N_BTN], a one-cycle pulse in the cycle btn_level[i] falls. It fires regardless of enable and lockout; reset value 0. Used for hold-to-drop release detection.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
Test parameters for all scenarios: DEBOUNCE_CYC=4, DAS_DELAY_CYC=10, ARR_CYC=3, REPEAT_MASK=4'b0001, enable=1 unless stated.
- Clean press: btn_raw[0] rises at cycle 0 and holds.
  - btn_level[0] and btn_pressed[0] go high at cycle 6.
  - Repeat pulses at cycles 16, 19, 22, ...
  - Release at cycle 23: btn_level[0] falls at cycle 29 with no further pulses.
- Glitch: btn_raw[1] high for 3 cycles, then low -> btn_level[1]=0 and btn_pressed[1]=0 throughout.
- Non-repeat button: btn_raw[2] held 50 cycles -> exactly one btn_pressed[2] pulse at cycle 6.
- Enable lockout:
  - btn_raw[0] pressed with enable=0; enable set to 1 at cycle 20 while still held -> no pulses.
  - Release, then re-press -> pulse 6 cycles after the re-press.
- Simultaneous press: btn_raw[0] and btn_raw[3] rise together -> both btn_pressed bits pulse at cycle 6.
- Reset mid-DAS: reset asserted for 1 cycle at cycle 10 while btn_raw[0] is held.
  - All outputs are 0 in the cycle after reset.
  - A new press pulse occurs 6 cycles after reset deasserts.
  - With BTN_RELEASE_PULSE_EN defined: no btn_released pulse is caused by the reset.

Source files
------------

// File: rtl/btn_repeat_ctrl.sv
// Button conditioning: 2-flop sync, debounce, press pulses and DAS/ARR auto-repeat per button.
// Optional BTN_RELEASE_PULSE_EN adds a btn_released one-cycle pulse output.
module btn_repeat_ctrl #(
    parameter int               N_BTN         = 4,
    parameter int               DEBOUNCE_CYC  = 250000,
    parameter int               DAS_DELAY_CYC = 4250000,
    parameter int               ARR_CYC       = 1250000,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(4'b1011)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pressed
`ifdef BTN_RELEASE_PULSE_EN
    ,
    output logic [N_BTN-1:0] btn_released
`endif
);

    localparam int RP_MAX = (DAS_DELAY_CYC > ARR_CYC) ? DAS_DELAY_CYC : ARR_CYC;
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LIMIT  = DB_W'(DEBOUNCE_CYC);
    localparam logic [RP_W-1:0] RP_ONE    = RP_W'(1);
    localparam logic [RP_W-1:0] DAS_LIMIT = RP_W'(DAS_DELAY_CYC);
    localparam logic [RP_W-1:0] ARR_LIMIT = RP_W'(ARR_CYC);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DAS  = 2'd1;
    localparam logic [1:0] ST_ARR  = 2'd2;

    genvar gi;
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
        logic            sync1_q;
        logic            sync2_q;
        logic            level_q;
        logic            level_d;
        logic            pressed_q;
        logic            pressed_d;
        logic            lockout_q;
        logic            lockout_d;
        logic [DB_W-1:0] db_cnt_q;
        logic [DB_W-1:0] db_cnt_d;
        logic [DB_W-1:0] db_cnt_inc_s;
        logic [RP_W-1:0] rp_cnt_q;
        logic [RP_W-1:0] rp_cnt_d;
        logic [RP_W-1:0] rp_cnt_inc_s;
        logic [1:0]      state_q;
        logic [1:0]      state_d;
        logic            rise_s;
        logic            fall_s;
        logic            pulse_ok_s;
        logic            rep_pulse_s;

        assign db_cnt_inc_s = db_cnt_q + DB_ONE;
        assign rp_cnt_inc_s = rp_cnt_q + RP_ONE;
        assign rise_s       = level_d & ~level_q;
        assign fall_s       = ~level_d & level_q;
        assign pulse_ok_s   = enable & ~lockout_q;

        // Debounce: level flips only after DEBOUNCE_CYC consecutive differing samples
        always_comb begin
            level_d  = level_q;
            db_cnt_d = '0;
            if (sync2_q != level_q) begin
                if (db_cnt_inc_s == DB_LIMIT) begin
                    level_d  = ~level_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_inc_s;
                end
            end else begin
                db_cnt_d = '0;
            end
        end

        // Lockout: a level seen high while paused stays mute until the button is released
        always_comb begin
            lockout_d = lockout_q;
            if (fall_s) begin
                lockout_d = 1'b0;
            end else if (!enable && level_q) begin
                lockout_d = 1'b1;
            end else begin
                lockout_d = lockout_q;
            end
        end

        // Repeat FSM: DAS wait after the press, then periodic ARR pulses while held
        always_comb begin
            state_d     = state_q;
            rp_cnt_d    = rp_cnt_q;
            rep_pulse_s = 1'b0;
            if (!REPEAT_MASK[gi] || !pulse_ok_s || fall_s) begin
                state_d  = ST_IDLE;
                rp_cnt_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        rp_cnt_d = '0;
                        if (rise_s) begin
                            state_d = ST_DAS;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DAS: begin
                        if (rp_cnt_inc_s == DAS_LIMIT) begin
                            rep_pulse_s = 1'b1;
                            rp_cnt_d    = '0;
                            state_d     = ST_ARR;
                        end else begin
                            rp_cnt_d = rp_cnt_inc_s;
                        end
                    end
                    ST_ARR: begin
                        if (rp_cnt_inc_s == ARR_LIMIT) begin
                            rep_pulse_s = 1'b1;
                            rp_cnt_d    = '0;
                        end else begin
                            rp_cnt_d = rp_cnt_inc_s;
                        end
                    end
                    default: begin
                        state_d  = ST_IDLE;
                        rp_cnt_d = '0;
                    end
                endcase
            end
        end

        assign pressed_d = pulse_ok_s & (rise_s | rep_pulse_s);

        // Per-button state registers
        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                level_q   <= 1'b0;
                pressed_q <= 1'b0;
                lockout_q <= 1'b0;
                db_cnt_q  <= '0;
                rp_cnt_q  <= '0;
                state_q   <= ST_IDLE;
            end else begin
                sync1_q   <= btn_raw[gi];
                sync2_q   <= sync1_q;
                level_q   <= level_d;
                pressed_q <= pressed_d;
                lockout_q <= lockout_d;
                db_cnt_q  <= db_cnt_d;
                rp_cnt_q  <= rp_cnt_d;
                state_q   <= state_d;
            end
        end

        assign btn_level[gi]   = level_q;
        assign btn_pressed[gi] = pressed_q;

`ifdef BTN_RELEASE_PULSE_EN
        logic released_q;

        // Release pulse ignores enable and lockout
        always_ff @(posedge clk) begin
            if (reset) begin
                released_q <= 1'b0;
            end else begin
                released_q <= fall_s;
            end
        end

        assign btn_released[gi] = released_q;
`endif
    end

endmodule

// File: tb/tb_btn_repeat_ctrl.sv
// Scoreboard bench for btn_repeat_ctrl: window-based reference model plus directed pulse-timing checks.
module tb_btn_repeat_ctrl;
    localparam int         N    = 4;
    localparam int         DEB  = 4;
    localparam int         DAS  = 10;
    localparam int         ARR  = 3;
    localparam logic [3:0] MASK = 4'b0001;
    localparam int         HMAX = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_pressed;
`ifdef BTN_RELEASE_PULSE_EN
    logic [3:0] btn_released;
`endif

    btn_repeat_ctrl #(
        .N_BTN(N), .DEBOUNCE_CYC(DEB), .DAS_DELAY_CYC(DAS), .ARR_CYC(ARR), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .enable(enable),
        .btn_level(btn_level),
        .btn_pressed(btn_pressed)
`ifdef BTN_RELEASE_PULSE_EN
        ,
        .btn_released(btn_released)
`endif
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] hist     [0:HMAX-1];
    logic [3:0] prs_seen [0:HMAX-1];
    logic [3:0] m_level  = 4'b0000;
    logic [3:0] m_lock   = 4'b0000;
    logic [3:0] m_active = 4'b0000;
    int         m_press_t [N];
    int         last_rst = 0;
    int         t0;
    int         t1;
    logic [3:0] raw_r;
    logic       en_r;
    logic       rst_r;

    // Reference model for edge t: a level changes once the synchronised input (raw delayed
    // two edges) has disagreed with it for DEB consecutive edges since the last reset.
    task automatic model_edge(input int t, input logic [3:0] raw, input logic en, input logic rst);
        exp_t       e;
        logic [3:0] nl;
        e = '0;
        if (rst) begin
            hist[t] = 4'b0000;
            if (t > 0) hist[t-1] = 4'b0000;
            last_rst = t;
            m_level  = 4'b0000;
            m_lock   = 4'b0000;
            m_active = 4'b0000;
            exp_q.push_back(e);
            return;
        end
        hist[t] = raw;
        nl = m_level;
        for (int i = 0; i < N; i++) begin
            logic all_diff;
            logic rise;
            logic fall;
            int   d;
            if (t - DEB >= last_rst) begin
                all_diff = 1'b1;
                for (int k = t - 1 - DEB; k <= t - 2; k++)
                    if (hist[k][i] == m_level[i]) all_diff = 1'b0;
                if (all_diff) nl[i] = ~m_level[i];
            end
            rise = nl[i] & ~m_level[i];
            fall = ~nl[i] & m_level[i];
            if (en && !m_lock[i]) begin
                if (rise) begin
                    e.prs[i] = 1'b1;
                    if (MASK[i]) begin
                        m_active[i]  = 1'b1;
                        m_press_t[i] = t;
                    end
                end else if (m_active[i] && !fall) begin
                    d = t - m_press_t[i];
                    if (d == DAS || (d > DAS && (d - DAS) % ARR == 0)) e.prs[i] = 1'b1;
                end
            end
            if (!en || fall) m_active[i] = 1'b0;
            if (fall) m_lock[i] = 1'b0;
            else if (!en && m_level[i]) m_lock[i] = 1'b1;
            e.rel[i] = fall;
        end
        m_level = nl;
        e.lvl   = nl;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expected response
    task automatic step(input logic [3:0] raw, input logic en, input logic rst);
        btn_raw = raw;
        enable  = en;
        reset   = rst;
        model_edge(cyc + 1, raw, en, rst);
        @(negedge clk);
    endtask

    function automatic logic [63:0] bm(input int k);
        bm = 64'd1 << k;
    endfunction

    task automatic check_pulses(input string name, input int b, input int base, input int len,
                                input logic [63:0] exp_mask);
        logic [63:0] obs;
        obs = 64'd0;
        for (int k = 1; k <= len; k++) obs[k] = prs_seen[base + k][b];
        n_tests++;
        if (obs !== exp_mask) begin
            n_fail++;
            $display("FAIL %s: pulse offsets got %h, expected %h", name, obs, exp_mask);
        end
    endtask

    // Monitor: compare every DUT output cycle against the oldest queued expectation
    always @(posedge clk) begin
        exp_t e;
        logic bad;
        #1;
        if (cyc < HMAX) prs_seen[cyc] = btn_pressed;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            bad = (btn_level !== e.lvl) || (btn_pressed !== e.prs);
`ifdef BTN_RELEASE_PULSE_EN
            bad = bad || (btn_released !== e.rel);
`endif
            n_tests++;
            if (bad) begin
                n_fail++;
`ifdef BTN_RELEASE_PULSE_EN
                $display("FAIL outputs cyc=%0d: level=%b pressed=%b released=%b, expected level=%b pressed=%b released=%b",
                         cyc, btn_level, btn_pressed, btn_released, e.lvl, e.prs, e.rel);
`else
                $display("FAIL outputs cyc=%0d: level=%b pressed=%b, expected level=%b pressed=%b",
                         cyc, btn_level, btn_pressed, e.lvl, e.prs);
`endif
            end
        end
    end

    initial begin
        btn_raw = 4'b0000;
        enable  = 1'b1;
        reset   = 1'b1;
        @(negedge clk);
        repeat (3) step(4'b0000, 1'b1, 1'b1);
        repeat (10) step(4'b0000, 1'b1, 1'b0);

        t0 = cyc;
        repeat (23) step(4'b0001, 1'b1, 1'b0);
        repeat (12) step(4'b0000, 1'b1, 1'b0);
        check_pulses("clean_press", 0, t0, 34, bm(6) | bm(16) | bm(19) | bm(22) | bm(25) | bm(28));

        t0 = cyc;
        repeat (3) step(4'b0010, 1'b1, 1'b0);
        repeat (12) step(4'b0000, 1'b1, 1'b0);
        check_pulses("glitch", 1, t0, 15, 64'd0);

        t0 = cyc;
        repeat (50) step(4'b0100, 1'b1, 1'b0);
        repeat (10) step(4'b0000, 1'b1, 1'b0);
        check_pulses("non_repeat", 2, t0, 60, bm(6));

        t0 = cyc;
        repeat (20) step(4'b0001, 1'b0, 1'b0);
        repeat (15) step(4'b0001, 1'b1, 1'b0);
        repeat (10) step(4'b0000, 1'b1, 1'b0);
        check_pulses("lockout_hold", 0, t0, 45, 64'd0);
        t1 = cyc;
        repeat (8) step(4'b0001, 1'b1, 1'b0);
        repeat (10) step(4'b0000, 1'b1, 1'b0);
        check_pulses("lockout_repress", 0, t1, 18, bm(6));

        t0 = cyc;
        repeat (8) step(4'b1001, 1'b1, 1'b0);
        repeat (10) step(4'b0000, 1'b1, 1'b0);
        check_pulses("simul_b0", 0, t0, 18, bm(6));
        check_pulses("simul_b3", 3, t0, 18, bm(6));

        t0 = cyc;
        repeat (10) step(4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b1, 1'b1);
        repeat (15) step(4'b0001, 1'b1, 1'b0);
        check_pulses("reset_mid_das", 0, t0, 26, bm(6) | bm(17));
        repeat (12) step(4'b0000, 1'b1, 1'b0);

        raw_r = 4'b0000;
        en_r  = 1'b1;
        for (int n = 0; n < 700; n++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 12) == 0) raw_r[b] = ~raw_r[b];
            if ($urandom_range(0, 49) == 0) en_r = ~en_r;
            rst_r = ($urandom_range(0, 299) == 0);
            step(raw_r, en_r, rst_r);
        end
        en_r = 1'b1;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 39) == 0) raw_r[b] = ~raw_r[b];
            if ($urandom_range(0, 149) == 0) en_r = ~en_r;
            step(raw_r, en_r, 1'b0);
        end
        repeat (15) step(4'b0000, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
